led_status_gen: RTL
===================

# led_status_gen

Generates the 13-bit LED status word consumed by the sprite/texture stage of the LED-counter demo. Advances the pattern at a frame-locked rate, offers four display modes and a pause, both driven by debounced push-buttons. Updates `o_status` only at the start of vertical blanking, so the sprite stage never shows a torn pattern.

## Interface
- `FRAMES_PER_STEP`, default 6: frames per pattern step; legal range 1..63.
- `DEBOUNCE_FRAMES`, default 3: consecutive frame samples required to accept a button level change; legal range 1..15.

Ports:
- `i_clk`  in  1: pixel clock.
- `i_rst_n`  in  1: asynchronous, active-low reset.
- `i_vsync_start`  in  1: one-cycle strobe at the start of vertical blanking (frame strobe).
- `i_btn_mode`  in  1: raw mode button, active-high, asynchronous to `i_clk`.
- `i_btn_pause`  in  1: raw pause button, active-high, asynchronous to `i_clk`.
- `o_status`  out  13: LED pattern; bit 12 is the leftmost LED.
- `o_mode`  out  2: current mode. 0 = COUNT_UP, 1 = COUNT_DOWN, 2 = SCANNER, 3 = GRAY.
- `o_paused`  out  1: high while stepping is paused.
- `o_step`  out  1: one-cycle pulse when `o_status` takes a new value because of a step or a mode change.

## Operation
- **Synchronisation:** each button passes through a 2-FF synchroniser.
- **Debounce:** each button has a stable level `deb` and a 4-bit counter `dcnt`, both updated only on a frame strobe.
  - If the synced level equals `deb`: `dcnt` is set to 0.
  - Otherwise `dcnt` increments. When the increment would reach `DEBOUNCE_FRAMES`, `deb` takes the synced level and `dcnt` clears.
  - A 0→1 change of `deb` produces a press event.
- **Frame counter `fcnt`** (6 bits) advances on each strobe while not paused. A strobe with `fcnt == FRAMES_PER_STEP-1` wraps `fcnt` to 0 and produces a step.
- **Mode press:** `mode <= mode+1` (wraps 3→0), `fcnt <= 0`, and the pattern is re-initialised:
  - `cnt` = 0.
  - Scanner position = 12, direction = right.
  - Entry value of `o_status`: modes 0, 1 and 3 show 0x0000; mode 2 shows 0x1000.
- **Pause press:** toggles `o_paused`. While paused, `fcnt` and the pattern hold. Mode presses are still applied.
- **Step behaviour per mode:**
  - COUNT_UP: `cnt+1` modulo 2^13 (0x1FFF→0x0000).
  - COUNT_DOWN: `cnt-1` modulo 2^13 (0x0000→0x1FFF).
  - SCANNER: one-hot bit moves 12,11,…,0,1,…,12. Direction reverses at each end without repeating the end position; period is 24 steps.
  - GRAY: `cnt` increments; `o_status = cnt ^ (cnt >> 1)`.
- **Simultaneous events on one strobe:**
  - Mode press plus step: the mode press wins and the step is discarded.
  - Mode press plus pause press: both are applied.
  - Pause press plus step: the step is applied and the pause takes effect from the next strobe.
- **Reset:** when `i_rst_n` goes low, all registers clear immediately with no clock needed. Outputs go to `o_status` = 0x0000, `o_mode` = 0, `o_paused` = 0, `o_step` = 0. Internal state resets to `fcnt` = 0, `cnt` = 0, scanner position = 12 with direction right, `deb` = 0 and `dcnt` = 0 for both buttons. A reset in mid-frame or mid-debounce discards all partial progress.

## Timing
- The strobe is sampled at clock edge T.
  - Edge T: debounce registers update. Press events and a delayed strobe are registered and are high during cycle T+1.
  - Edge T+1: mode, pause, `fcnt`, `cnt` and scanner update, along with `o_mode` and `o_paused`.
  - Edge T+2: `o_status` updates and `o_step` pulses for cycle T+2 only.
- Between strobes, `o_status` is constant.
- A button level must be present at least 2 cycles before a strobe for that strobe to count it.
- Latency from a button level to a visible mode change: `DEBOUNCE_FRAMES` strobes plus 2 cycles.
- Strobes arriving closer together than 3 cycles are not supported.

## Test plan
- Reset, mode 0, `FRAMES_PER_STEP`=6, 12 strobes: `o_status` goes 0x0000→0x0001 two cycles after strobe 6, and →0x0002 after strobe 12. Exactly two `o_step` pulses.
- Wrap: preload by stepping COUNT_UP to 0x1FFF; the next step gives 0x0000. Press mode once (COUNT_DOWN); the first step gives 0x1FFF.
- Debounce, `DEBOUNCE_FRAMES`=3:
  - Mode button high across 3 strobes: `o_mode` = 1 two cycles after strobe 3, `o_status` = 0x0000.
  - Pattern high, high, low, high: no mode change.
  - Mode press coinciding with a step strobe: step discarded, `fcnt` = 0.
- Scanner: entering mode 2 gives 0x1000. After 12 steps 0x0001, step 13 gives 0x0002, step 24 gives 0x1000.
- Pause:
  - Press pause with `fcnt` = 3, then 20 strobes: `o_status` and `fcnt` hold, no `o_step` pulses.
  - Press pause again: the step occurs on the 3rd strobe after resumption.
  - Mode press while paused: `o_mode` advances with `o_paused` still 1.
- Asynchronous reset: drop `i_rst_n` between clock edges while in GRAY mode with `cnt` = 5 and debounce mid-count. All outputs read 0 before the next edge. After release, the first step gives 0x0001 in mode 0.

Source files
------------

// File: rtl/led_status_gen.sv
// LED status word generator: frame-locked pattern stepping with four display
// modes and pause, controlled by debounced buttons; o_status changes only after a strobe.

module led_status_btn #(
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_strobe,
  input  logic i_btn,
  output logic o_press
);
  localparam logic [3:0] DEB_LIM = 4'(DEBOUNCE_FRAMES);

  logic [1:0] sync;
  logic       deb;
  logic [3:0] dcnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync    <= '0;
      deb     <= 1'b0;
      dcnt    <= '0;
      o_press <= 1'b0;
    end else begin
      sync    <= {sync[0], i_btn};
      o_press <= 1'b0;
      if (i_strobe) begin
        if (sync[1] == deb) begin
          dcnt <= '0;
        end else if (dcnt + 4'd1 == DEB_LIM) begin
          deb     <= sync[1];
          dcnt    <= '0;
          o_press <= sync[1];
        end else begin
          dcnt <= dcnt + 4'd1;
        end
      end
    end
  end
endmodule

module led_status_gen #(
  parameter int FRAMES_PER_STEP = 6,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_vsync_start,
  input  logic        i_btn_mode,
  input  logic        i_btn_pause,
  output logic [12:0] o_status,
  output logic [1:0]  o_mode,
  output logic        o_paused,
  output logic        o_step
);
  localparam int         NUM_BTN  = 2;
  localparam logic [5:0] FCNT_END = 6'(FRAMES_PER_STEP - 1);
  localparam logic [3:0] POS_TOP  = 4'd12;

  logic [NUM_BTN-1:0] raw, press;
  assign raw = {i_btn_pause, i_btn_mode};

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    led_status_btn #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_btn (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_strobe (i_vsync_start),
      .i_btn    (raw[gi]),
      .o_press  (press[gi])
    );
  end

  logic        strb_d, upd, paused, dir_left;
  logic [1:0]  mode;
  logic [5:0]  fcnt;
  logic [12:0] cnt, status_nxt;
  logic [3:0]  pos;

  // Pattern state advances one cycle after the strobe, when press events are valid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      strb_d   <= 1'b0;
      upd      <= 1'b0;
      paused   <= 1'b0;
      mode     <= '0;
      fcnt     <= '0;
      cnt      <= '0;
      pos      <= POS_TOP;
      dir_left <= 1'b0;
    end else begin
      strb_d <= i_vsync_start;
      upd    <= 1'b0;
      if (strb_d) begin
        if (press[1]) paused <= ~paused;
        if (press[0]) begin
          mode     <= mode + 2'd1;
          fcnt     <= '0;
          cnt      <= '0;
          pos      <= POS_TOP;
          dir_left <= 1'b0;
          upd      <= 1'b1;
        end else if (!paused) begin
          if (fcnt == FCNT_END) begin
            fcnt <= '0;
            upd  <= 1'b1;
            if (mode == 2'd1) cnt <= cnt - 13'd1;
            else if (mode != 2'd2) cnt <= cnt + 13'd1;
            // Scanner bounces between 12 and 0 without dwelling on the ends.
            if (mode == 2'd2) begin
              if (!dir_left && pos == 4'd0) begin
                pos      <= 4'd1;
                dir_left <= 1'b1;
              end else if (dir_left && pos == POS_TOP) begin
                pos      <= POS_TOP - 4'd1;
                dir_left <= 1'b0;
              end else begin
                pos <= dir_left ? pos + 4'd1 : pos - 4'd1;
              end
            end
          end else begin
            fcnt <= fcnt + 6'd1;
          end
        end
      end
    end
  end

  always_comb begin
    status_nxt = cnt;
    case (mode)
      2'd2:    status_nxt = 13'd1 << pos;
      2'd3:    status_nxt = cnt ^ (cnt >> 1);
      default: status_nxt = cnt;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_status <= '0;
      o_step   <= 1'b0;
    end else begin
      o_step <= upd;
      if (upd) o_status <= status_nxt;
    end
  end

  assign o_mode   = mode;
  assign o_paused = paused;
endmodule
